// File: rtl/result_tx_sequencer.sv
// result_tx_sequencer: frames each SAD match result into a 6-byte UART packet over a start/busy handshake
module result_tx_sequencer #(
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter logic [15:0] ACK_TIMEOUT = 16'd50000
) (
  input  logic       clock,
  input  logic       notReset,
  input  logic       result_valid,
  input  logic       match,
  input  logic [9:0] x_in,
  input  logic [8:0] y_in,
  input  logic       clear_flags,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       send_complete,
  output logic       busy,
  output logic       overrun,
  output logic       timeout_err
);
  typedef enum logic [2:0] {IDLE, ARM, WAIT_ACK, WAIT_DONE, DONE} state_t;
  state_t state, state_nx;
  logic match_q;
  logic [9:0] x_q;
  logic [8:0] y_q;
  logic [2:0] idx;
  logic [15:0] ack_cnt;
  logic [7:0] chk;
  logic [5:0][7:0] frame;
  logic start_hit, next_byte, timeout_hit, overrun_hit;
  assign chk = HEADER ^ {match_q, 5'b0, x_q[9:8]} ^ x_q[7:0] ^ {7'b0, y_q[8]} ^ y_q[7:0];
  assign frame = {chk, y_q[7:0], {7'b0, y_q[8]}, x_q[7:0], {match_q, 5'b0, x_q[9:8]}, HEADER};
  assign send_complete = state == DONE;
  assign busy = state != IDLE;
  // next state plus the handshake events that steer the datapath
  always_comb begin
    state_nx = state;
    start_hit = 1'b0;
    next_byte = 1'b0;
    timeout_hit = 1'b0;
    overrun_hit = result_valid && state != IDLE;
    case (state)
      IDLE: state_nx = result_valid ? ARM : IDLE;
      ARM: begin
        start_hit = !tx_busy;
        state_nx = tx_busy ? ARM : WAIT_ACK;
      end
      WAIT_ACK: begin
        timeout_hit = !tx_busy && ack_cnt == ACK_TIMEOUT - 16'd1;
        state_nx = tx_busy ? WAIT_DONE : timeout_hit ? IDLE : WAIT_ACK;
      end
      WAIT_DONE: begin
        next_byte = !tx_busy && idx != 3'd5;
        state_nx = tx_busy ? WAIT_DONE : idx == 3'd5 ? DONE : ARM;
      end
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clock or negedge notReset)
    if (!notReset) state <= IDLE;
    else state <= state_nx;
  // capture, byte sequencing, ack timer and sticky flags
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      match_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      idx <= '0;
      ack_cnt <= '0;
      tx_data <= '0;
      tx_start <= 1'b0;
      overrun <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tx_start <= start_hit;
      if (state == IDLE && result_valid) begin
        match_q <= match;
        x_q <= x_in;
        y_q <= y_in;
        idx <= '0;
        tx_data <= HEADER;
      end
      if (next_byte) begin
        idx <= idx + 3'd1;
        tx_data <= frame[idx + 3'd1];
      end
      ack_cnt <= start_hit ? 16'd0 : (state == WAIT_ACK && !tx_busy) ? ack_cnt + 16'd1 : ack_cnt;
      overrun <= overrun_hit || (overrun && !clear_flags);
      timeout_err <= timeout_hit || (timeout_err && !clear_flags);
    end
  end
endmodule

// File: tb/tb_result_tx_sequencer.sv
// tb_result_tx_sequencer: randomized and directed checks of the result frame sequencer against a handshake-level model
module tb_result_tx_sequencer;
  localparam int T = 64;
  localparam int P_IDLE = 0, P_WANT = 1, P_ACK = 2, P_DONEW = 3, P_FIN = 4;
  logic clock = 0, notReset = 0, result_valid = 0, match = 0, clear_flags = 0;
  logic [9:0] x_in = 0;
  logic [8:0] y_in = 0;
  logic uart_busy = 0, force_busy = 0;
  logic tx_busy;
  logic [7:0] tx_data;
  logic tx_start, send_complete, busy, overrun, timeout_err;
  assign tx_busy = uart_busy | force_busy;
  result_tx_sequencer #(.HEADER(8'hA5), .ACK_TIMEOUT(16'(T))) dut (
    .clock(clock), .notReset(notReset), .result_valid(result_valid), .match(match),
    .x_in(x_in), .y_in(y_in), .clear_flags(clear_flags), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_start(tx_start), .send_complete(send_complete),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );
  always #5 clock = ~clock;
  int n_chk = 0, n_fail = 0, n_sc = 0;
  logic [7:0] got[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] fbyte(input int k, input int x, input int y, input int m);
    int b[6];
    b[0] = 165;
    b[1] = m * 128 + x / 256;
    b[2] = x % 256;
    b[3] = y / 256;
    b[4] = y % 256;
    b[5] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
    return 8'(b[k]);
  endfunction
  // UART transmitter model: raises busy ack_dly cycles after a start, holds it hold_len cycles
  bit ack_en = 1;
  int ack_dly = 2, hold_len = 10, u_dly = 0, u_hold = 0;
  always @(posedge clock) begin
    #1;
    if (!notReset) begin
      u_dly = 0;
      u_hold = 0;
      uart_busy = 0;
    end else begin
      if (u_hold > 0) begin
        u_hold--;
        if (u_hold == 0) uart_busy = 0;
      end else if (u_dly > 0) begin
        u_dly--;
        if (u_dly == 0) begin
          uart_busy = 1;
          u_hold = hold_len;
        end
      end
      if (tx_start && ack_en) u_dly = ack_dly;
    end
  end
  // reference model: pending bytes of the current frame and the handshake phase they are in
  int phase = P_IDLE, w = 0;
  logic [7:0] q[$];
  logic [7:0] cur = 0;
  bit m_busy = 0, m_start = 0, m_sc = 0, m_ovr = 0, m_to = 0, ovr_set, to_set;
  always @(posedge clock) begin
    if (!notReset) begin
      phase = P_IDLE;
      q.delete();
      m_busy = 0; m_start = 0; m_sc = 0; m_ovr = 0; m_to = 0; w = 0;
    end else begin
      ovr_set = result_valid && m_busy;
      to_set = 0;
      m_start = 0;
      m_sc = 0;
      case (phase)
        P_IDLE: if (result_valid) begin
          for (int k = 0; k < 6; k++) q.push_back(fbyte(k, x_in, y_in, match));
          phase = P_WANT;
          m_busy = 1;
        end
        P_WANT: if (!tx_busy) begin
          cur = q.pop_front();
          m_start = 1;
          w = 0;
          phase = P_ACK;
        end
        P_ACK: if (tx_busy) phase = P_DONEW;
        else begin
          w++;
          if (w == T) begin
            to_set = 1;
            q.delete();
            m_busy = 0;
            phase = P_IDLE;
          end
        end
        P_DONEW: if (!tx_busy) begin
          if (q.size() == 0) begin
            m_sc = 1;
            phase = P_FIN;
          end else phase = P_WANT;
        end
        default: begin
          phase = P_IDLE;
          m_busy = 0;
        end
      endcase
      m_ovr = ovr_set || (m_ovr && !clear_flags);
      m_to = to_set || (m_to && !clear_flags);
    end
  end
  // per-cycle compare of every output against the model
  always @(negedge clock) begin
    if (!notReset) chk("reset_outputs", {tx_data, tx_start, send_complete, busy, overrun, timeout_err}, 0);
    else begin
      chk("busy", busy, m_busy);
      chk("tx_start", tx_start, m_start);
      chk("send_complete", send_complete, m_sc);
      chk("overrun", overrun, m_ovr);
      chk("timeout_err", timeout_err, m_to);
      if (phase == P_ACK || phase == P_DONEW) chk("tx_data_stable", tx_data, cur);
      if (tx_start) got.push_back(tx_data);
      if (send_complete) n_sc++;
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic send(input int x, input int y, input int m);
    x_in = 10'(x);
    y_in = 9'(y);
    match = 1'(m);
    result_valid = 1;
    tick();
    result_valid = 0;
  endtask
  task automatic wait_idle(input int budget);
    int c = 0;
    while ((m_busy || uart_busy) && c < budget) begin
      tick();
      c++;
    end
    chk("wait_idle_in_budget", c < budget, 1);
    tick(2);
  endtask
  task automatic wait_phase(input int ph, input int qs, input int budget);
    int c = 0;
    while (!(phase == ph && q.size() == qs) && c < budget) begin
      tick();
      c++;
    end
    chk("wait_phase_in_budget", c < budget, 1);
  endtask
  task automatic check_frame(input string name, input logic [47:0] lit);
    chk({name, "_count"}, got.size(), 6);
    for (int k = 0; k < 6 && k < got.size(); k++) chk(name, got[k], lit[47 - 8 * k -: 8]);
  endtask
  initial begin
    int sc0, x, y, m, c;
    tick(3);
    notReset = 1;
    tick(2);
    for (int k = 0; k < 6; k++) begin
      chk("model_pin_t1", fbyte(k, 321, 200, 1), 48'hA5_81_41_00_C8_AD >> (40 - 8 * k) & 48'hFF);
      chk("model_pin_t2", fbyte(k, 639, 479, 0), 48'hA5_02_7F_01_DF_06 >> (40 - 8 * k) & 48'hFF);
    end
    got.delete(); sc0 = n_sc;
    send(321, 200, 1);
    wait_idle(400);
    check_frame("t1_frame", 48'hA5_81_41_00_C8_AD);
    chk("t1_send_complete", n_sc - sc0, 1);
    got.delete(); sc0 = n_sc;
    send(639, 479, 0);
    wait_idle(400);
    check_frame("t2_frame", 48'hA5_02_7F_01_DF_06);
    chk("t2_flags", {overrun, timeout_err}, 0);
    got.delete(); sc0 = n_sc;
    force_busy = 1;
    tick(3);
    send(0, 0, 0);
    tick(16);
    chk("t3_start_withheld", got.size(), 0);
    force_busy = 0;
    wait_idle(400);
    check_frame("t3_frame", 48'hA5_00_00_00_00_A5);
    got.delete(); sc0 = n_sc;
    ack_en = 0;
    send(5, 6, 1);
    wait_idle(T + 50);
    chk("t4_timeout_err", timeout_err, 1);
    chk("t4_busy", busy, 0);
    chk("t4_one_start", got.size(), 1);
    chk("t4_no_send_complete", n_sc - sc0, 0);
    ack_en = 1;
    got.delete();
    send(321, 200, 1);
    wait_idle(400);
    check_frame("t4_retry_frame", 48'hA5_81_41_00_C8_AD);
    chk("t4_retry_send_complete", n_sc - sc0, 1);
    clear_flags = 1;
    tick();
    clear_flags = 0;
    chk("t4_cleared", timeout_err, 0);
    got.delete(); sc0 = n_sc;
    send(639, 479, 0);
    wait_phase(P_ACK, 2, 400);
    send(7, 7, 1);
    chk("t5_overrun_set", overrun, 1);
    wait_idle(400);
    check_frame("t5_frame", 48'hA5_02_7F_01_DF_06);
    clear_flags = 1;
    tick();
    clear_flags = 0;
    chk("t5_overrun_cleared", overrun, 0);
    got.delete(); sc0 = n_sc;
    send(321, 200, 1);
    wait_phase(P_DONEW, 3, 400);
    notReset = 0;
    #1;
    chk("t6_async_reset", {tx_data, tx_start, send_complete, busy, overrun, timeout_err}, 0);
    tick(3);
    notReset = 1;
    got.delete();
    tick(40);
    chk("t6_no_start", got.size(), 0);
    chk("t6_no_send_complete", n_sc - sc0, 0);
    for (int i = 0; i < 20; i++) begin
      x = $urandom_range(0, 1023);
      y = $urandom_range(0, 511);
      m = $urandom_range(0, 1);
      ack_dly = $urandom_range(1, 4);
      hold_len = $urandom_range(1, 8);
      got.delete(); sc0 = n_sc;
      send(x, y, m);
      c = 0;
      while ((m_busy || uart_busy) && c < 2000) begin
        if (m_busy && $urandom_range(0, 15) == 0) begin
          x_in = 10'($urandom);
          y_in = 9'($urandom);
          match = 1'($urandom);
          result_valid = 1;
        end
        if ($urandom_range(0, 15) == 0) clear_flags = 1;
        tick();
        result_valid = 0;
        clear_flags = 0;
        c++;
      end
      chk("rnd_in_budget", c < 2000, 1);
      tick(2);
      chk("rnd_count", got.size(), 6);
      for (int k = 0; k < 6 && k < got.size(); k++) chk("rnd_byte", got[k], fbyte(k, x, y, m));
      chk("rnd_send_complete", n_sc - sc0, 1);
    end
    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #600000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
